// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared FSM state and mode encodings for down_timer.
package down_timer_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-cycle terminal-count pulse, one-shot or auto-reload.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic             stop,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;
  logic             load_ok;
  logic             last;
  assign load_ok = start && (load_value != '0);
  // A zero count never reaches RUN, so a count of one marks expiry.
  assign last    = count_q == WIDTH'(1);
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (load_ok) begin
      state_d  = RUN;
      count_d  = load_value;
      reload_d = load_value;
      mode_d   = periodic;
    end else if (state_q == RUN && stop) begin
      state_d = IDLE;
    end else if (state_q == RUN && enable) begin
      tc_d    = last;
      count_d = !last ? count_q - WIDTH'(1) : (mode_q == MODE_PERIODIC ? reload_q : '0);
      state_d = (last && mode_q == MODE_ONESHOT) ? IDLE : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end
  assign count = count_q;
  assign busy  = state_q == RUN;
  assign tc    = tc_q;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed checks of down_timer load, countdown, modes, stop, restart and async reset.
module tb_down_timer;
  localparam int WIDTH = 8;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             periodic = 1'b0;
  logic             stop = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  int               n_run = 0;
  int               n_fail = 0;
  down_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .load_value(load_value), .periodic(periodic),
    .stop(stop), .enable(enable), .count(count), .busy(busy), .tc(tc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect3(input string tag, input int c, input int b, input int t);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tc"}, 32'(tc), 32'(t));
  endtask
  task automatic load(input int v, input logic p);
    start = 1'b1;
    load_value = WIDTH'(v);
    periodic = p;
    step();
    start = 1'b0;
  endtask
  initial begin
    int m;
    int e;
    #2;
    expect3("reset", 0, 0, 0);
    step();
    rst = 1'b0;
    enable = 1'b1;
    // one-shot V=3
    load(3, 1'b0);
    expect3("os3.load", 3, 1, 0);
    step(); expect3("os3.e1", 2, 1, 0);
    step(); expect3("os3.e2", 1, 1, 0);
    step(); expect3("os3.e3", 0, 0, 1);
    step(); expect3("os3.after", 0, 0, 0);
    // periodic V=4 for 12 cycles
    load(4, 1'b1);
    expect3("per4.load", 4, 1, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      expect3($sformatf("per4.e%0d", k), 4 - (k % 4), 1, (k % 4) == 0 ? 1 : 0);
    end
    stop = 1'b1;
    step(); expect3("per4.stop", 4, 0, 0);
    stop = 1'b0;
    // one-shot V=5 with enable toggling
    load(5, 1'b0);
    m = 5;
    for (int k = 1; k <= 11; k++) begin
      enable = k[0];
      step();
      e = 0;
      if (k[0] && m > 0) begin
        e = (m == 1);
        m = m - 1;
      end
      expect3($sformatf("tog5.e%0d", k), m, m != 0 ? 1 : 0, e);
    end
    enable = 1'b1;
    // stop mid-run, then restart
    load(6, 1'b0);
    step(); step(); step();
    expect3("stop6.pre", 3, 1, 0);
    stop = 1'b1;
    step(); expect3("stop6.stop", 3, 0, 0);
    stop = 1'b0;
    step(); expect3("stop6.idle", 3, 0, 0);
    load(2, 1'b0);
    expect3("re2.load", 2, 1, 0);
    step(); expect3("re2.e1", 1, 1, 0);
    step(); expect3("re2.e2", 0, 0, 1);
    // zero load ignored in IDLE
    load(0, 1'b1);
    expect3("zero.idle", 0, 0, 0);
    step(); expect3("zero.idle2", 0, 0, 0);
    // zero load ignored while running; enable still counts
    load(5, 1'b0);
    load(0, 1'b0);
    expect3("zero.run", 4, 1, 0);
    // start beats stop on the same edge
    stop = 1'b1;
    load(7, 1'b0);
    stop = 1'b0;
    expect3("startstop", 7, 1, 0);
    step(); expect3("startstop.e1", 6, 1, 0);
    // disabled cycles hold
    enable = 1'b0;
    step(); step(); expect3("hold", 6, 1, 0);
    enable = 1'b1;
    // periodic V=1: tc continuously
    load(1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step();
      expect3($sformatf("per1.e%0d", k), 1, 1, 1);
    end
    // max load value
    load(255, 1'b0);
    step(); expect3("max.e1", 254, 1, 0);
    // async reset at count=2 in periodic mode
    load(3, 1'b1);
    step();
    expect3("rst.pre", 2, 1, 0);
    rst = 1'b1;
    #1;
    expect3("rst.async", 0, 0, 0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      expect3($sformatf("rst.post%0d", k), 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
